// File: rtl/fetch_redirect_ctrl_pkg.sv
// fetch_redirect_ctrl_pkg
// Shared constants and types for the fetch redirect controller:
//   pc_size        - default PC width
//   PC_INC         - sequential fetch increment
//   redir_state_t  - controller FSM states (RUN, HOLD)
//   redir_src_t    - which source won the redirect arbitration
// Optional feature macro used by this slice: TRAP_REDIRECT_EN.
package fetch_redirect_ctrl_pkg;

    localparam int          pc_size = 32;
    localparam logic [31:0] PC_INC  = 32'd4;

    typedef enum logic {
        RUN  = 1'b0,
        HOLD = 1'b1
    } redir_state_t;

    typedef enum logic [1:0] {
        SRC_SEQ  = 2'd0,
        SRC_BPU  = 2'd1,
        SRC_EX   = 2'd2,
        SRC_TRAP = 2'd3
    } redir_src_t;

    // Trap and execute redirects both squash IF and ID and are counted.
    function automatic logic is_hard_redirect(input redir_src_t src);
        return (src == SRC_EX) || (src == SRC_TRAP);
    endfunction

endpackage

// File: rtl/fetch_redirect_ctrl_if.sv
// fetch_redirect_ctrl_if
// Bundles the fetch redirect controller's pipeline-facing signals.
//   master : pipeline side (BPU, imem, execute, trap unit) - drives requests
//   slave  : fetch_redirect_ctrl - drives PC and squash controls
// trap_req/trap_vec exist only when TRAP_REDIRECT_EN is defined.
interface fetch_redirect_ctrl_if #(
    parameter int PC_W = fetch_redirect_ctrl_pkg::pc_size
);
    logic            fetch_rdy;
    logic            stall_id;
    logic            bpu_sel;
    logic [PC_W-1:0] bpu_npc;
    logic            bpu_nop;
    logic            ex_req;
    logic [PC_W-1:0] ex_pc;
`ifdef TRAP_REDIRECT_EN
    logic            trap_req;
    logic [PC_W-1:0] trap_vec;
`endif
    logic [PC_W-1:0] pc_q;
    logic [PC_W-1:0] pcplf;
    logic            pc_en;
    logic            kill_if;
    logic            kill_id;
    logic            redir_pend;
    logic [15:0]     redir_cnt;

    modport master (
        output fetch_rdy, stall_id, bpu_sel, bpu_npc, bpu_nop, ex_req, ex_pc,
`ifdef TRAP_REDIRECT_EN
        output trap_req, trap_vec,
`endif
        input  pc_q, pcplf, pc_en, kill_if, kill_id, redir_pend, redir_cnt
    );

    modport slave (
        input  fetch_rdy, stall_id, bpu_sel, bpu_npc, bpu_nop, ex_req, ex_pc,
`ifdef TRAP_REDIRECT_EN
        input  trap_req, trap_vec,
`endif
        output pc_q, pcplf, pc_en, kill_if, kill_id, redir_pend, redir_cnt
    );

endinterface

// File: rtl/fetch_redirect_ctrl_redir_arbiter.sv
// redir_arbiter
// Purely combinational priority select of the next-PC source:
// trap > ex > bpu > sequential.
//   trap_req/trap_vec : trap redirect (tied off by the parent when unused)
//   ex_req/ex_pc      : execute-stage late redirect
//   bpu_sel/bpu_npc   : branch predictor selection
//   seq_pc            : sequential next PC (pc_q + 4)
//   src/target        : winning source and its target address
module redir_arbiter
    import fetch_redirect_ctrl_pkg::*;
#(
    parameter int PC_W = pc_size
) (
    input  logic            trap_req,
    input  logic [PC_W-1:0] trap_vec,
    input  logic            ex_req,
    input  logic [PC_W-1:0] ex_pc,
    input  logic            bpu_sel,
    input  logic [PC_W-1:0] bpu_npc,
    input  logic [PC_W-1:0] seq_pc,
    output redir_src_t      src,
    output logic [PC_W-1:0] target
);

    // Fixed-priority source/target selection.
    always_comb begin
        src    = SRC_SEQ;
        target = seq_pc;
        if (trap_req) begin
            src    = SRC_TRAP;
            target = trap_vec;
        end else if (ex_req) begin
            src    = SRC_EX;
            target = ex_pc;
        end else if (bpu_sel) begin
            src    = SRC_BPU;
            target = bpu_npc;
        end else begin
            src    = SRC_SEQ;
            target = seq_pc;
        end
    end

endmodule

// File: rtl/fetch_redirect_ctrl.sv
// fetch_redirect_ctrl
// Owns the fetch PC register and sequences every redirect into it.
// A trap/execute redirect that arrives while instruction memory is not
// ready is parked in pend_pc (HOLD) until fetch_rdy returns.
// Ports:
//   clk   - rising-edge clock
//   nrst  - synchronous active-low reset
//   bus   - fetch_redirect_ctrl_if.slave: BPU/imem/execute/trap inputs,
//           pc_q, pcplf, pc_en, kill_if, kill_id, redir_pend, redir_cnt
// Config macro: TRAP_REDIRECT_EN adds the trap_req/trap_vec redirect
// source with top priority; without it pend_trap can never be set.
module fetch_redirect_ctrl
    import fetch_redirect_ctrl_pkg::*;
#(
    parameter int              PC_W     = pc_size,
    parameter logic [PC_W-1:0] RESET_PC = 32'h0000_0000
) (
    input  logic                  clk,
    input  logic                  nrst,
    fetch_redirect_ctrl_if.slave  bus
);

    localparam logic [PC_W-1:0] PC_STEP = PC_W'(PC_INC);

    redir_state_t    state_r;
    redir_state_t    state_next_s;
    logic [PC_W-1:0] pc_r;
    logic [PC_W-1:0] pc_next_s;
    logic [PC_W-1:0] pend_pc_r;
    logic [PC_W-1:0] pend_pc_next_s;
    logic            pend_trap_r;
    logic            pend_trap_next_s;
    logic [15:0]     cnt_r;
    logic            cnt_inc_s;
    logic            redir_pend_r;
    logic            pc_en_s;
    logic            kill_if_s;
    logic            kill_id_s;
    logic [PC_W-1:0] pcplf_s;
    logic            trap_req_s;
    logic [PC_W-1:0] trap_vec_s;
    redir_src_t      src_s;
    logic [PC_W-1:0] tgt_s;

`ifdef TRAP_REDIRECT_EN
    assign trap_req_s = bus.trap_req;
    assign trap_vec_s = bus.trap_vec;
`else
    assign trap_req_s = 1'b0;
    assign trap_vec_s = {PC_W{1'b0}};
`endif

    assign pcplf_s = pc_r + PC_STEP;

    redir_arbiter #(.PC_W(PC_W)) u_arb (
        .trap_req (trap_req_s),
        .trap_vec (trap_vec_s),
        .ex_req   (bus.ex_req),
        .ex_pc    (bus.ex_pc),
        .bpu_sel  (bus.bpu_sel),
        .bpu_npc  (bus.bpu_npc),
        .seq_pc   (pcplf_s),
        .src      (src_s),
        .target   (tgt_s)
    );

    // Every trap/ex request seen is counted, including one shadowed by a
    // pending trap; a simultaneous trap+ex pair counts once.
    assign cnt_inc_s = trap_req_s | bus.ex_req;

    // Next-state, next-PC, pending-redirect and squash decode.
    always_comb begin
        state_next_s     = state_r;
        pc_next_s        = pc_r;
        pend_pc_next_s   = pend_pc_r;
        pend_trap_next_s = pend_trap_r;
        pc_en_s          = 1'b0;
        kill_if_s        = 1'b0;
        kill_id_s        = 1'b0;
        case (state_r)
            RUN: begin
                if (is_hard_redirect(src_s)) begin
                    kill_if_s = 1'b1;
                    kill_id_s = 1'b1;
                    if (bus.fetch_rdy) begin
                        pc_en_s   = 1'b1;
                        pc_next_s = tgt_s;
                    end else begin
                        pend_pc_next_s   = tgt_s;
                        pend_trap_next_s = (src_s == SRC_TRAP);
                        state_next_s     = HOLD;
                    end
                end else if ((src_s == SRC_BPU) && bus.fetch_rdy) begin
                    // A predicted redirect proceeds even under a decode stall.
                    pc_en_s   = 1'b1;
                    pc_next_s = tgt_s;
                    kill_if_s = bus.bpu_nop;
                end else begin
                    pc_en_s   = bus.fetch_rdy & ~bus.stall_id;
                    kill_if_s = bus.bpu_nop;
                    if (pc_en_s) begin
                        pc_next_s = pcplf_s;
                    end else begin
                        pc_next_s = pc_r;
                    end
                end
            end
            HOLD: begin
                // The IF slot is always squashed here, so BPU input is moot.
                kill_if_s = 1'b1;
                if (trap_req_s) begin
                    pend_pc_next_s   = trap_vec_s;
                    pend_trap_next_s = 1'b1;
                end else if (bus.ex_req && !pend_trap_r) begin
                    pend_pc_next_s = bus.ex_pc;
                end else begin
                    pend_pc_next_s = pend_pc_r;
                end
                // Release with the newest pending target.
                if (bus.fetch_rdy) begin
                    pc_en_s          = 1'b1;
                    pc_next_s        = pend_pc_next_s;
                    pend_trap_next_s = 1'b0;
                    state_next_s     = RUN;
                end else begin
                    state_next_s = HOLD;
                end
            end
            default: begin
                state_next_s = RUN;
            end
        endcase
    end

    // State, PC, pending-redirect and counter registers.
    always_ff @(posedge clk) begin
        if (!nrst) begin
            state_r      <= RUN;
            pc_r         <= RESET_PC;
            pend_pc_r    <= {PC_W{1'b0}};
            pend_trap_r  <= 1'b0;
            cnt_r        <= 16'h0000;
            redir_pend_r <= 1'b0;
        end else begin
            state_r      <= state_next_s;
            pc_r         <= pc_next_s;
            pend_pc_r    <= pend_pc_next_s;
            pend_trap_r  <= pend_trap_next_s;
            redir_pend_r <= (state_next_s == HOLD);
            if (cnt_inc_s && (cnt_r != 16'hFFFF)) begin
                cnt_r <= cnt_r + 16'd1;
            end else begin
                cnt_r <= cnt_r;
            end
        end
    end

    // Control outputs are forced quiet while reset is asserted.
    assign bus.pc_q       = pc_r;
    assign bus.pcplf      = pcplf_s;
    assign bus.pc_en      = pc_en_s & nrst;
    assign bus.kill_if    = kill_if_s & nrst;
    assign bus.kill_id    = kill_id_s & nrst;
    assign bus.redir_pend = redir_pend_r & nrst;
    assign bus.redir_cnt  = cnt_r;

endmodule

// File: tb/tb_fetch_redirect_ctrl.sv
// tb_fetch_redirect_ctrl
// Directed scoreboard bench for fetch_redirect_ctrl (RESET_PC = 32'h100).
// Each step drives inputs, checks the combinational controls, queues the
// expected post-edge registered state, and compares it after the edge.
// Trap scenarios are included when TRAP_REDIRECT_EN is defined.
module tb_fetch_redirect_ctrl;

    logic clk = 1'b0;
    logic nrst;

    // Free-running clock, period 10.
    always #5 clk = ~clk;

    fetch_redirect_ctrl_if #(.PC_W(32)) bus();

    fetch_redirect_ctrl #(.PC_W(32), .RESET_PC(32'h0000_0100)) dut (
        .clk  (clk),
        .nrst (nrst),
        .bus  (bus)
    );

    typedef struct {
        string       tag;
        logic [31:0] pc;
        logic [15:0] cnt;
        logic        pend;
    } exp_t;

    exp_t        sb_q[$];
    int          total_cnt = 0;
    int          bad_cnt   = 0;
    logic [31:0] cur_pc_exp;
    int          base_cnt;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total_cnt++;
        if (obs !== exp) begin
            bad_cnt++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // One clock step: drive, check combinational outputs, queue and check registered state.
    task automatic cyc(input string tag, input logic rst_v, input logic fr, input logic sid,
                       input logic bs, input logic [31:0] bnpc, input logic bnop,
                       input logic er, input logic [31:0] epc,
                       input logic e_en, input logic e_kif, input logic e_kid,
                       input logic [31:0] e_pc, input logic [15:0] e_cnt, input logic e_pend);
        exp_t e;
        nrst          = rst_v;
        bus.fetch_rdy = fr;
        bus.stall_id  = sid;
        bus.bpu_sel   = bs;
        bus.bpu_npc   = bnpc;
        bus.bpu_nop   = bnop;
        bus.ex_req    = er;
        bus.ex_pc     = epc;
        #1;
        check_val({tag, ".pc_en"},   32'(bus.pc_en),   32'(e_en));
        check_val({tag, ".kill_if"}, 32'(bus.kill_if), 32'(e_kif));
        check_val({tag, ".kill_id"}, 32'(bus.kill_id), 32'(e_kid));
        if (rst_v) begin
            check_val({tag, ".pcplf"}, bus.pcplf, cur_pc_exp + 32'd4);
        end
        e.tag  = tag;
        e.pc   = e_pc;
        e.cnt  = e_cnt;
        e.pend = e_pend;
        sb_q.push_back(e);
        @(posedge clk);
        #1;
        e = sb_q.pop_front();
        check_val({e.tag, ".pc_q"},       bus.pc_q,               e.pc);
        check_val({e.tag, ".redir_cnt"},  32'(bus.redir_cnt),     32'(e.cnt));
        check_val({e.tag, ".redir_pend"}, 32'(bus.redir_pend),    32'(e.pend));
        cur_pc_exp = e.pc;
    endtask

    // Directed stimulus sequence.
    initial begin
        cur_pc_exp = 32'h0000_0000;
        base_cnt   = 0;
`ifdef TRAP_REDIRECT_EN
        bus.trap_req = 1'b0;
        bus.trap_vec = 32'h0000_0000;
`endif
        //   tag          rst fr sid bs bnpc          nop er epc           en kif kid pc            cnt       pend
        cyc("rst0",      1'b0,1'b1,1'b0,1'b0,32'h0,1'b0,1'b0,32'h0,      1'b0,1'b0,1'b0,32'h100,     16'd0,1'b0);
        cyc("rst1",      1'b0,1'b1,1'b0,1'b0,32'h0,1'b0,1'b1,32'h40,     1'b0,1'b0,1'b0,32'h100,     16'd0,1'b0);
        cyc("seq",       1'b1,1'b1,1'b0,1'b0,32'h0,1'b0,1'b0,32'h0,      1'b1,1'b0,1'b0,32'h104,     16'd0,1'b0);
        cyc("bpu_stall", 1'b1,1'b1,1'b1,1'b1,32'h200,1'b0,1'b0,32'h0,    1'b1,1'b0,1'b0,32'h200,     16'd0,1'b0);
        cyc("stall",     1'b1,1'b1,1'b1,1'b0,32'h0,1'b0,1'b0,32'h0,      1'b0,1'b0,1'b0,32'h200,     16'd0,1'b0);
        cyc("bpu_nop",   1'b1,1'b1,1'b0,1'b0,32'h0,1'b1,1'b0,32'h0,      1'b1,1'b1,1'b0,32'h204,     16'd0,1'b0);
        cyc("ex_bpu",    1'b1,1'b1,1'b0,1'b1,32'h400,1'b0,1'b1,32'h300,  1'b1,1'b1,1'b1,32'h300,     16'd1,1'b0);
        cyc("ex_nrdy",   1'b1,1'b0,1'b0,1'b0,32'h0,1'b0,1'b1,32'h500,    1'b0,1'b1,1'b1,32'h300,     16'd2,1'b1);
        cyc("hold1",     1'b1,1'b0,1'b0,1'b1,32'h700,1'b1,1'b0,32'h0,    1'b0,1'b1,1'b0,32'h300,     16'd2,1'b1);
        cyc("hold2",     1'b1,1'b0,1'b0,1'b1,32'h700,1'b0,1'b0,32'h0,    1'b0,1'b1,1'b0,32'h300,     16'd2,1'b1);
        cyc("release",   1'b1,1'b1,1'b1,1'b1,32'h700,1'b0,1'b0,32'h0,    1'b1,1'b1,1'b0,32'h500,     16'd2,1'b0);
        cyc("seq2",      1'b1,1'b1,1'b0,1'b0,32'h0,1'b0,1'b0,32'h0,      1'b1,1'b0,1'b0,32'h504,     16'd2,1'b0);
        cyc("ex_nrdy2",  1'b1,1'b0,1'b0,1'b0,32'h0,1'b0,1'b1,32'h600,    1'b0,1'b1,1'b1,32'h504,     16'd3,1'b1);
        cyc("hold_ovr",  1'b1,1'b0,1'b0,1'b0,32'h0,1'b0,1'b1,32'h640,    1'b0,1'b1,1'b0,32'h504,     16'd4,1'b1);
        cyc("release2",  1'b1,1'b1,1'b0,1'b0,32'h0,1'b0,1'b0,32'h0,      1'b1,1'b1,1'b0,32'h640,     16'd4,1'b0);
        cyc("ex_wrap",   1'b1,1'b1,1'b0,1'b0,32'h0,1'b0,1'b1,32'hFFFF_FFFC,1'b1,1'b1,1'b1,32'hFFFF_FFFC,16'd5,1'b0);
        cyc("wrap",      1'b1,1'b1,1'b0,1'b0,32'h0,1'b0,1'b0,32'h0,      1'b1,1'b0,1'b0,32'h0,       16'd5,1'b0);
        cyc("idle",      1'b1,1'b0,1'b0,1'b0,32'h0,1'b0,1'b0,32'h0,      1'b0,1'b0,1'b0,32'h0,       16'd5,1'b0);
        cyc("ex_nrdy3",  1'b1,1'b0,1'b0,1'b0,32'h0,1'b0,1'b1,32'h700,    1'b0,1'b1,1'b1,32'h0,       16'd6,1'b1);
        cyc("rst_hold",  1'b0,1'b0,1'b0,1'b0,32'h0,1'b0,1'b0,32'h0,      1'b0,1'b0,1'b0,32'h100,     16'd0,1'b0);
        cyc("post_rst",  1'b1,1'b1,1'b0,1'b0,32'h0,1'b0,1'b0,32'h0,      1'b1,1'b0,1'b0,32'h104,     16'd0,1'b0);
`ifdef TRAP_REDIRECT_EN
        bus.trap_req = 1'b1;
        bus.trap_vec = 32'h0000_0080;
        cyc("trap_ex",   1'b1,1'b0,1'b0,1'b0,32'h0,1'b0,1'b1,32'h900,    1'b0,1'b1,1'b1,32'h104,     16'd1,1'b1);
        bus.trap_req = 1'b0;
        cyc("hold_ex",   1'b1,1'b0,1'b0,1'b0,32'h0,1'b0,1'b1,32'h904,    1'b0,1'b1,1'b0,32'h104,     16'd2,1'b1);
        cyc("trap_rel",  1'b1,1'b1,1'b0,1'b0,32'h0,1'b0,1'b0,32'h0,      1'b1,1'b1,1'b0,32'h80,      16'd2,1'b0);
        base_cnt = 2;
`endif
        // Run the counter up to its ceiling with back-to-back accepted redirects.
        for (int i = 0; i < 65535 - base_cnt; i++) begin
            nrst          = 1'b1;
            bus.fetch_rdy = 1'b1;
            bus.stall_id  = 1'b0;
            bus.bpu_sel   = 1'b0;
            bus.bpu_nop   = 1'b0;
            bus.ex_req    = 1'b1;
            bus.ex_pc     = 32'h0000_1000;
            @(posedge clk);
            #1;
        end
        bus.ex_req = 1'b0;
        cur_pc_exp = 32'h0000_1000;
        check_val("sat_reach", 32'(bus.redir_cnt), 32'h0000_FFFF);
        check_val("sat_pc", bus.pc_q, 32'h0000_1000);
        cyc("sat_hold",  1'b1,1'b1,1'b0,1'b0,32'h0,1'b0,1'b1,32'h2000,   1'b1,1'b1,1'b1,32'h2000,    16'hFFFF,1'b0);
        cyc("sat_seq",   1'b1,1'b1,1'b0,1'b0,32'h0,1'b0,1'b0,32'h0,      1'b1,1'b0,1'b0,32'h2004,    16'hFFFF,1'b0);

        $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
        $finish;
    end

endmodule

// File: doc/fetch_redirect_ctrl.md
# fetch_redirect_ctrl

Sequencer for the fetch stage's program counter. It owns the PC register and arbitrates every source that can redirect fetch: trap vector, execute-stage late redirect (branch resolution or JALR), and the branch prediction unit's npc/mux_sel. It holds a redirect pending while instruction memory is not ready, and generates the PC enable plus the IF/ID squash signals. It sits between the branch prediction unit, the instruction memory port and the decode/execute control unit.

## Interface
Parameters:
- PC_W, 32, PC width (matches pc_size)
- RESET_PC, 32'h0000_0000, PC value loaded at reset

Ports:
- clk  in  1  clock, rising edge
- nrst  in  1  reset nrst, synchronous, active-low
- fetch_rdy  in  1  instruction memory accepts a fetch at pc_q this cycle
- stall_id  in  1  decode hazard stall, freezes sequential fetch
- bpu_sel  in  1  BPU mux select: take bpu_npc
- bpu_npc  in  PC_W  BPU next PC
- bpu_nop  in  1  BPU request to squash the instruction in IF
- ex_req  in  1  execute-stage redirect request (one-cycle pulse)
- ex_pc  in  PC_W  execute-stage redirect target
- trap_req  in  1  trap redirect pulse (TRAP_REDIRECT_EN only)
- trap_vec  in  PC_W  trap handler address (TRAP_REDIRECT_EN only)
- pc_q  out  PC_W  current fetch PC
- pcplf  out  PC_W  pc_q + 4
- pc_en  out  1  pc_q updates at next edge
- kill_if  out  1  squash the IF/ID instruction
- kill_id  out  1  squash the ID/EX instruction
- redir_pend  out  1  a redirect is held waiting for fetch_rdy
- redir_cnt  out  16  saturating count of accepted ex/trap redirects

## Operation
- Priority: trap > ex > bpu > sequential (pc_q + 4).
- States: RUN, HOLD.
- RUN:
  - Trap or ex request with fetch_rdy=1: pc_q <= target. kill_if=1, kill_id=1. Stay in RUN.
  - Trap or ex request with fetch_rdy=0: latch target and source into pend_pc/pend_trap. kill_if=1, kill_id=1. Go to HOLD.
  - No trap/ex request, bpu_sel=1, fetch_rdy=1: pc_q <= bpu_npc, even when stall_id=1. kill_if = bpu_nop.
  - No redirect: pc_en = fetch_rdy & ~stall_id. pc_q <= pcplf. kill_if = bpu_nop.
- HOLD:
  - bpu_sel and bpu_nop are ignored; the instruction they refer to is already squashed.
  - kill_if=1 every cycle in HOLD.
  - A new ex_req overwrites pend_pc unless pend_trap=1. trap_req always overwrites.
  - When fetch_rdy=1: pc_en=1, pc_q <= pend_pc, go to RUN.
- redir_cnt increments by 1 on each accepted ex/trap request (RUN or HOLD overwrite) and saturates at 16'hFFFF.
- All PC arithmetic is modulo 2^PC_W; pcplf wraps from 32'hFFFF_FFFC to 0.

## Timing
- Reset values: pc_q=RESET_PC, state=RUN, pend_pc=0, pend_trap=0, redir_cnt=0. pc_en, kill_if, kill_id and redir_pend are 0 during the reset cycle.
- pc_en, kill_if, kill_id and pcplf are combinational from current inputs and state. pc_q and redir_cnt are registered.
- Redirect latency: ex_req in cycle N with fetch_rdy=1 puts the target on pc_q in N+1.
- redir_pend = (state == HOLD), registered.
- Simultaneous trap_req and ex_req: trap wins, and only one count is added.
- nrst low mid-HOLD discards the pending redirect.

## Configuration
- TRAP_REDIRECT_EN defined: trap_req/trap_vec ports exist, with top priority.
- TRAP_REDIRECT_EN undefined: both ports are removed and pend_trap is tied to 0. All other behaviour is unchanged.

## Structure
- Shared constants package:
  - pc_size
  - PC increment constant (4)
  - state enum typedef redir_state_t {RUN, HOLD}
  - redirect-source enum {SRC_SEQ, SRC_BPU, SRC_EX, SRC_TRAP}
- One natural sub-module, redir_arbiter: purely combinational priority select producing source and target. The FSM, PC register and counter stay in the top module.

## Test plan
- Reset with RESET_PC=32'h100 -> pc_q=32'h100, redir_cnt=0. First edge with fetch_rdy=1, stall_id=0 -> pc_q=32'h104.
- bpu_sel=1, bpu_npc=32'h200, stall_id=1, fetch_rdy=1 -> next pc_q=32'h200, kill_id=0.
- ex_req with ex_pc=32'h300 and bpu_sel=1 (bpu_npc=32'h400) in the same cycle, fetch_rdy=1 -> pc_q=32'h300, kill_if=kill_id=1, redir_cnt=1.
- ex_req with ex_pc=32'h500 and fetch_rdy=0 for 3 cycles -> redir_pend=1 and kill_if=1 for those cycles, bpu_sel ignored. fetch_rdy rising -> pc_q=32'h500 next edge, redir_pend=0.
- TRAP_REDIRECT_EN defined: trap_req (trap_vec=32'h80) and ex_req in the same cycle, then ex_req again during HOLD -> pc_q=32'h80 after release, redir_cnt=2.
- pc_q=32'hFFFF_FFFC, sequential fetch -> pc_q=0. Force redir_cnt=16'hFFFF, then ex_req -> redir_cnt stays 16'hFFFF.
